mem_access: RTL and testbench

- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX result bundle: aluop, mem_addr, reg2 store data, wdata, rd, wreg.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW over the byte-wide RAM port; every other op passes through to WB.
- Multi-cycle FSM; holds the upstream pipeline through stall_req_o while an access is in flight.

---
 rtl/mem_access_pkg.sv | 53 +++++
 rtl/mem_byte_seq.sv | 43 ++++
 rtl/mem_access.sv | 194 +++++++++++++++++++
 tb/tb_mem_access.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: aluop codes for loads and stores,
// FSM state encoding, bus widths and small access-classification helpers.
package mem_access_pkg;

  localparam int          RegBus     = 32;
  localparam int          RegAddrBus = 5;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        RstEnable  = 1'b0;

  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_ADD_OP = 8'h20;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {ACC_NONE, ACC_LOAD, ACC_STORE} acc_kind_t;

  function automatic acc_kind_t acc_kind(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP: return ACC_LOAD;
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         return ACC_STORE;
      default:                                                 return ACC_NONE;
    endcase
  endfunction

  // Number of bytes moved by a memory op; 0 for anything else.
  function automatic logic [2:0] acc_len(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 3'd1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 3'd2;
      EXE_LW_OP, EXE_SW_OP:             return 3'd4;
      default:                          return 3'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    logic [2:0] n;
    n = acc_len(op);
    return ((n == 3'd2) && a[0]) || ((n == 3'd4) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer shared by the load and store paths: holds the access
// length, walks the byte address (wrapping modulo 2^ADDR_W) and counts bytes.
module mem_byte_seq
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        len,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        idx,
  output logic              last,
  output logic              over
);

  logic [2:0] len_q;

  // Load base/length on start, otherwise advance one byte per step.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      addr  <= '0;
      idx   <= 3'd0;
      len_q <= 3'd0;
    end else if (start) begin
      addr  <= base;
      idx   <= 3'd0;
      len_q <= len;
    end else if (step) begin
      addr  <= addr + 1'b1;
      idx   <= idx + 3'd1;
    end
  end

  // last marks the final RAM cycle; over marks the extra load cycle that
  // catches the final read byte.
  assign last = (idx == (len_q - 3'd1));
  assign over = (idx == len_q);

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: byte-serial loads/stores over an 8-bit
// RAM port, with pass-through of non-memory results to WB.
// Optional macro MEM_ALIGN_CHECK_EN adds misalign_o and turns misaligned
// halfword/word accesses into RAM-less, non-writing results.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int OP_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [OP_W-1:0]       aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           reg2_i,
  input  logic [31:0]           wdata_i,
  input  logic [RegAddrBus-1:0] rd_i,
  input  logic                  wreg_i,
  input  logic [7:0]            ram_din_i,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  valid_o,
  output logic [RegAddrBus-1:0] rd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic                  stall_req_o
);

  logic [1:0]            state;
  logic [OP_W-1:0]       op_q;
  logic [31:0]           sdata_q;
  logic [31:0]           ldata_q;
  logic [31:0]           ldata_next;
  logic [RegAddrBus-1:0] rd_q;
  logic                  wreg_q;

  acc_kind_t   kind_in;
  logic [2:0]  len_in;
  logic        mem_req;
  logic        bad_align;
  logic        seq_start;
  logic        seq_step;
  logic [2:0]  seq_idx;
  logic        seq_last;
  logic        seq_over;
  logic        unused_addr_hi;

  assign kind_in = acc_kind(8'(aluop_i));
  assign len_in  = acc_len(8'(aluop_i));
  assign mem_req = valid_i && (kind_in != ACC_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = misaligned(8'(aluop_i), mem_addr_i[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  assign unused_addr_hi = ^mem_addr_i[31:ADDR_W];

  assign seq_start = (state == ST_IDLE) && mem_req && !bad_align;
  assign seq_step  = (state == ST_LOAD) || (state == ST_STORE);

  mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (seq_start),
    .step  (seq_step),
    .base  (mem_addr_i[ADDR_W-1:0]),
    .len   (len_in),
    .addr  (ram_addr_o),
    .idx   (seq_idx),
    .last  (seq_last),
    .over  (seq_over)
  );

  // Stall while an access is in flight or about to start; released in DONE.
  assign stall_req_o = (state == ST_LOAD) || (state == ST_STORE) ||
                       ((state == ST_IDLE) && mem_req);

  // Write strobe follows the state so an async reset drops it at once.
  assign ram_wr_o = (state == ST_STORE);

  // Present store byte k during store cycle k (little-endian).
  always_comb begin
    ram_dout_o = sdata_q[7:0];
    case (seq_idx[1:0])
      2'd1:    ram_dout_o = sdata_q[15:8];
      2'd2:    ram_dout_o = sdata_q[23:16];
      2'd3:    ram_dout_o = sdata_q[31:24];
      default: ram_dout_o = sdata_q[7:0];
    endcase
  end

  // Load cycle k (k >= 1) sees the byte addressed in cycle k-1; drop it in lane k-1.
  always_comb begin
    ldata_next = ldata_q;
    case (seq_idx)
      3'd1:    ldata_next[7:0]   = ram_din_i;
      3'd2:    ldata_next[15:8]  = ram_din_i;
      3'd3:    ldata_next[23:16] = ram_din_i;
      3'd4:    ldata_next[31:24] = ram_din_i;
      default: ldata_next = ldata_q;
    endcase
  end

  function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [31:0] d);
    case (op)
      EXE_LB_OP:  return {{24{d[7]}}, d[7:0]};
      EXE_LBU_OP: return {24'h0, d[7:0]};
      EXE_LH_OP:  return {{16{d[15]}}, d[15:0]};
      EXE_LHU_OP: return {16'h0, d[15:0]};
      default:    return d;
    endcase
  endfunction

  // Access FSM and WB result register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state   <= ST_IDLE;
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
      rd_o    <= '0;
      wdata_o <= ZeroWord;
      op_q    <= '0;
      sdata_q <= ZeroWord;
      ldata_q <= ZeroWord;
      rd_q    <= '0;
      wreg_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (kind_in == ACC_NONE) begin
              valid_o <= 1'b1;
              rd_o    <= rd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else begin
              op_q    <= aluop_i;
              sdata_q <= reg2_i;
              rd_q    <= rd_i;
              wreg_q  <= wreg_i;
              ldata_q <= ZeroWord;
              if (bad_align) begin
                state   <= ST_DONE;
                valid_o <= 1'b1;
                rd_o    <= rd_i;
                wdata_o <= ZeroWord;
`ifdef MEM_ALIGN_CHECK_EN
                misalign_o <= 1'b1;
`endif
              end else begin
                state <= (kind_in == ACC_LOAD) ? ST_LOAD : ST_STORE;
              end
            end
          end
        end
        ST_LOAD: begin
          ldata_q <= ldata_next;
          if (seq_over) begin
            state   <= ST_DONE;
            valid_o <= 1'b1;
            rd_o    <= rd_q;
            wreg_o  <= wreg_q;
            wdata_o <= load_extend(8'(op_q), ldata_next);
          end
        end
        ST_STORE: begin
          if (seq_last) begin
            state   <= ST_DONE;
            valid_o <= 1'b1;
            rd_o    <= rd_q;
            wdata_o <= ZeroWord;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-array model.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int ADDR_W = 17;
  localparam int OP_W   = 8;
  localparam int MSZ    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [OP_W-1:0]   aluop_i;
  logic [31:0]       mem_addr_i, reg2_i, wdata_i;
  logic [4:0]        rd_i;
  logic              wreg_i;
  logic [7:0]        ram_din_i;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic              valid_o;
  logic [4:0]        rd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;
  logic              stall_req_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalign_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] last_wdata;

  logic [7:0] ram     [MSZ];
  logic [7:0] ref_mem [MSZ];

  mem_access #(.ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .wdata_i     (wdata_i),
    .rd_i        (rd_i),
    .wreg_i      (wreg_i),
    .ram_din_i   (ram_din_i),
    .ram_addr_o  (ram_addr_o),
    .ram_wr_o    (ram_wr_o),
    .ram_dout_o  (ram_dout_o),
    .valid_o     (valid_o),
    .rd_o        (rd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_o  (misalign_o),
`endif
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  // Byte RAM: synchronous write, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Expected load result straight from the model memory and extension rules.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input int base);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(base + i) % MSZ];
    case (op)
      EXE_LB_OP:  return 32'(signed'(w[7:0]));
      EXE_LBU_OP: return 32'(w[7:0]);
      EXE_LH_OP:  return 32'(signed'(w[15:0]));
      EXE_LHU_OP: return 32'(w[15:0]);
      default:    return w;
    endcase
  endfunction

  // Present one bundle, follow it cycle by cycle, and return to IDLE.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [31:0] wd, input logic [4:0] rd, input logic wr);
    int n;
    int base;
    logic mis;
    logic [31:0] exp;
    n    = len_of(op);
    base = int'(addr[ADDR_W-1:0]);
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    exp = ref_load(op, base);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2;
    wdata_i = wd; rd_i = rd; wreg_i = wr;
    #1;
    check("stall_at_issue", {31'b0, stall_req_o}, {31'b0, n != 0});
    if (n == 0) begin
      @(posedge clk); #1;
      check("pass_valid", {31'b0, valid_o}, 32'd1);
      check("pass_wdata", wdata_o, wd);
      check("pass_rd", {27'b0, rd_o}, {27'b0, rd});
      check("pass_wreg", {31'b0, wreg_o}, {31'b0, wr});
      check("pass_stall", {31'b0, stall_req_o}, 32'd0);
      last_wdata = wdata_o;
    end else if (mis) begin
      @(posedge clk); #1;
      check("mis_valid", {31'b0, valid_o}, 32'd1);
      check("mis_wreg", {31'b0, wreg_o}, 32'd0);
      check("mis_wdata", wdata_o, 32'd0);
      check("mis_wr", {31'b0, ram_wr_o}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      check("mis_flag", {31'b0, misalign_o}, 32'd1);
`endif
    end else if (is_store(op)) begin
      for (int j = 0; j < n; j++) begin
        @(posedge clk); #1;
        check("st_wr", {31'b0, ram_wr_o}, 32'd1);
        check("st_addr", 32'(ram_addr_o), 32'((base + j) % MSZ));
        check("st_byte", {24'b0, ram_dout_o}, {24'b0, r2[8*j +: 8]});
        check("st_stall", {31'b0, stall_req_o}, 32'd1);
        check("st_valid_lo", {31'b0, valid_o}, 32'd0);
        ref_mem[(base + j) % MSZ] = r2[8*j +: 8];
      end
      @(posedge clk); #1;
      check("st_done_valid", {31'b0, valid_o}, 32'd1);
      check("st_done_wreg", {31'b0, wreg_o}, 32'd0);
      check("st_done_wdata", wdata_o, 32'd0);
      check("st_done_wr", {31'b0, ram_wr_o}, 32'd0);
      check("st_done_stall", {31'b0, stall_req_o}, 32'd0);
    end else begin
      for (int j = 0; j <= n; j++) begin
        @(posedge clk); #1;
        check("ld_stall", {31'b0, stall_req_o}, 32'd1);
        check("ld_valid_lo", {31'b0, valid_o}, 32'd0);
        check("ld_wr", {31'b0, ram_wr_o}, 32'd0);
        if (j < n) check("ld_addr", 32'(ram_addr_o), 32'((base + j) % MSZ));
      end
      @(posedge clk); #1;
      check("ld_done_valid", {31'b0, valid_o}, 32'd1);
      check("ld_done_stall", {31'b0, stall_req_o}, 32'd0);
      check("ld_wdata", wdata_o, exp);
      check("ld_wreg", {31'b0, wreg_o}, {31'b0, wr});
      check("ld_rd", {27'b0, rd_o}, {27'b0, rd});
      last_wdata = wdata_o;
    end
`ifdef MEM_ALIGN_CHECK_EN
    if (n != 0 && !mis) check("mis_flag_lo", {31'b0, misalign_o}, 32'd0);
`endif
    valid_i = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", {31'b0, valid_o}, 32'd0);
    check("idle_wreg", {31'b0, wreg_o}, 32'd0);
  endtask

  logic [7:0] op_tab [10] = '{EXE_ADD_OP, EXE_OR_OP, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
                              EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    rst = 1'b0; valid_i = 1'b0; aluop_i = '0; mem_addr_i = '0; reg2_i = '0;
    wdata_i = '0; rd_i = '0; wreg_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_wreg", {31'b0, wreg_o}, 32'd0);
    check("rst_wr", {31'b0, ram_wr_o}, 32'd0);
    check("rst_stall", {31'b0, stall_req_o}, 32'd0);
    check("rst_rd", {27'b0, rd_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_addr", 32'(ram_addr_o), 32'd0);
    check("rst_dout", {24'b0, ram_dout_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(EXE_ADD_OP, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
    check("add_result", last_wdata, 32'h0000_1234);

    ram[17'h100] = 8'h78; ram[17'h101] = 8'h56; ram[17'h102] = 8'h34; ram[17'h103] = 8'h12;
    ref_mem[17'h100] = 8'h78; ref_mem[17'h101] = 8'h56;
    ref_mem[17'h102] = 8'h34; ref_mem[17'h103] = 8'h12;
    run_op(EXE_LW_OP, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1);
    check("lw_word", last_wdata, 32'h1234_5678);

    ram[17'h20] = 8'h80; ram[17'h21] = 8'hFF;
    ref_mem[17'h20] = 8'h80; ref_mem[17'h21] = 8'hFF;
    run_op(EXE_LB_OP, 32'h20, 32'h0, 32'h0, 5'd1, 1'b1);
    check("lb_sext", last_wdata, 32'hFFFF_FF80);
    run_op(EXE_LBU_OP, 32'h20, 32'h0, 32'h0, 5'd2, 1'b1);
    check("lbu_zext", last_wdata, 32'h0000_0080);
    run_op(EXE_LH_OP, 32'h20, 32'h0, 32'h0, 5'd3, 1'b1);
    check("lh_sext", last_wdata, 32'hFFFF_FF80);

`ifndef MEM_ALIGN_CHECK_EN
    run_op(EXE_SW_OP, 32'h0001_FFFF, 32'hAABB_CCDD, 32'h0, 5'd0, 1'b0);
    check("sw_wrap_b0", {24'b0, ram[17'h1FFFF]}, 32'hDD);
    check("sw_wrap_b1", {24'b0, ram[17'h0]}, 32'hCC);
    check("sw_wrap_b2", {24'b0, ram[17'h1]}, 32'hBB);
    check("sw_wrap_b3", {24'b0, ram[17'h2]}, 32'hAA);
`else
    run_op(EXE_LW_OP, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1);
`endif

    // Reset in the third cycle of a word store.
    valid_i = 1'b1; aluop_i = EXE_SW_OP; mem_addr_i = 32'h300; reg2_i = 32'h1122_3344;
    rd_i = 5'd0; wreg_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_wr", {31'b0, ram_wr_o}, 32'd1);
    rst = 1'b0; valid_i = 1'b0;
    #1;
    check("abort_wr", {31'b0, ram_wr_o}, 32'd0);
    check("abort_valid", {31'b0, valid_o}, 32'd0);
    check("abort_stall", {31'b0, stall_req_o}, 32'd0);
    ref_mem[17'h300] = 8'h44; ref_mem[17'h301] = 8'h33;
    @(posedge clk); #1;
    check("abort_hold_valid", {31'b0, valid_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_after_valid", {31'b0, valid_o}, 32'd0);
    run_op(EXE_LW_OP, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1);
    check("abort_partial", {16'b0, last_wdata[15:0]}, 32'h3344);

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[ADDR_W-1:0] = 17'h1FFFC + 17'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("bubble_valid", {31'b0, valid_o}, 32'd0);
      end
      run_op(op_tab[$urandom_range(0, 9)], a, $urandom, $urandom,
             5'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
